// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, RGB565 field positions and the output-alignment pipeline word
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int R_MSB = 15;
  localparam int G_MSB = 10;
  localparam int B_MSB = 4;
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic brd;
    logic fs;
  } vga_ctl_t;
  function automatic int cnt_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, raw syncs, active area and frame-boundary strobes
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = cnt_w(H_TOTAL),
  localparam int VW = cnt_w(V_TOTAL)
) (
  input  logic          vga_clk,
  input  logic          rst,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          active,
  output logic          active_nxt,
  output logic          hsync_raw,
  output logic          vsync_raw,
  output logic          frame_end,
  output logic          frame_first
);
  logic line_end;
  logic [HW-1:0] hcnt_nxt;
  logic [VW-1:0] vcnt_nxt;
  always_comb begin
    line_end = hcnt == HW'(H_TOTAL - 1);
    frame_end = line_end && vcnt == VW'(V_TOTAL - 1);
    hcnt_nxt = line_end ? '0 : hcnt + 1'b1;
    vcnt_nxt = frame_end ? '0 : line_end ? vcnt + 1'b1 : vcnt;
    active = hcnt < HW'(H_ACTIVE) && vcnt < VW'(V_ACTIVE);
    active_nxt = hcnt_nxt < HW'(H_ACTIVE) && vcnt_nxt < VW'(V_ACTIVE);
    hsync_raw = hcnt >= HW'(H_ACTIVE + H_FP) && hcnt < HW'(H_ACTIVE + H_FP + H_SYNC);
    vsync_raw = vcnt >= VW'(V_ACTIVE + V_FP) && vcnt < VW'(V_ACTIVE + V_FP + V_SYNC);
    frame_first = hcnt == '0 && vcnt == '0;
  end
  always_ff @(posedge vga_clk or posedge rst)
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= hcnt_nxt;
      vcnt <= vcnt_nxt;
    end
endmodule

// File: rtl/vga_display_pipe.sv
// vga_display_pipe: VGA timing, linear picture addressing, frame-latched warning select with blinking border, RGB565 to 4:4:4
module vga_display_pipe
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter bit SYNC_ACT = 1'b0,
  parameter int ADDR_W = 19,
  parameter int RD_LAT = 1,
  parameter int BORDER = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              vga_clk,
  input  logic              rst,
  input  logic              warning_signal,
  input  logic [15:0]       pic_data,
  output logic              hor_syn,
  output logic              ver_syn,
  output logic              pic_select,
  output logic [3:0]        rgb_red,
  output logic [3:0]        rgb_green,
  output logic [3:0]        rgb_blue,
  output logic [ADDR_W-1:0] pic_addr,
  output logic              frame_start
);
  localparam int HW = cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int FW = cnt_w(BLINK_FRAMES);
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic active, active_nxt, hsync_raw, vsync_raw, frame_end, frame_first;
  logic [1:0] warn_sync;
  logic [FW-1:0] fcnt;
  logic blink_on, on_edge, unused_bits;
  vga_ctl_t ctl_raw, ctl_out;
  vga_ctl_t pipe [RD_LAT];
  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .vga_clk(vga_clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt), .active(active),
    .active_nxt(active_nxt), .hsync_raw(hsync_raw), .vsync_raw(vsync_raw),
    .frame_end(frame_end), .frame_first(frame_first)
  );
  // address tracks the pixel the counters point at, so it steps when the next pixel is visible
  always_ff @(posedge vga_clk or posedge rst)
    if (rst) pic_addr <= '0;
    else if (frame_end) pic_addr <= '0;
    else if (active_nxt) pic_addr <= pic_addr + 1'b1;
  always_ff @(posedge vga_clk or posedge rst)
    if (rst) begin
      warn_sync <= '0;
      pic_select <= 1'b0;
      fcnt <= '0;
      blink_on <= 1'b1;
    end else begin
      warn_sync <= {warn_sync[0], warning_signal};
      if (frame_end) begin
        pic_select <= warn_sync[1];
        if (!pic_select || !warn_sync[1]) begin
          fcnt <= '0;
          blink_on <= 1'b1;
        end else if (fcnt == FW'(BLINK_FRAMES - 1)) begin
          fcnt <= '0;
          blink_on <= ~blink_on;
        end else fcnt <= fcnt + 1'b1;
      end
    end
  always_comb begin
    on_edge = hcnt < HW'(BORDER) || hcnt >= HW'(H_ACTIVE - BORDER) ||
              vcnt < VW'(BORDER) || vcnt >= VW'(V_ACTIVE - BORDER);
    ctl_raw = {hsync_raw, vsync_raw, active, active && on_edge && pic_select && blink_on, frame_first};
  end
  always_ff @(posedge vga_clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= ctl_raw;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  assign ctl_out = pipe[RD_LAT-1];
  assign unused_bits = ^{pic_data[11], pic_data[6:5], pic_data[0]};
  always_comb begin
    hor_syn = ctl_out.hs ? SYNC_ACT : ~SYNC_ACT;
    ver_syn = ctl_out.vs ? SYNC_ACT : ~SYNC_ACT;
    frame_start = ctl_out.fs;
    rgb_red = !ctl_out.act ? 4'h0 : ctl_out.brd ? 4'hF : pic_data[R_MSB -: 4];
    rgb_green = ctl_out.act && !ctl_out.brd ? pic_data[G_MSB -: 4] : 4'h0;
    rgb_blue = ctl_out.act && !ctl_out.brd ? pic_data[B_MSB -: 4] : 4'h0;
  end
endmodule

// File: tb/tb_vga_display_pipe.sv
// tb_vga_display_pipe: randomized warning/picture stimulus against a per-cycle raster reference model
module tb_vga_display_pipe;
  localparam int HA = 16, HFP = 3, HS = 5, HBP = 4;
  localparam int VA = 10, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int AW = 8, LAT = 2, BD = 2, BF = 2;
  localparam bit SA = 1'b0;
  logic clk = 1'b0;
  logic rst, warning;
  logic [15:0] pic_data;
  logic hor_syn, ver_syn, pic_select, frame_start;
  logic [3:0] rgb_red, rgb_green, rgb_blue;
  logic [AW-1:0] pic_addr;
  logic [15:0] mem [1<<AW];
  logic [15:0] rd_q [LAT] = '{default: 16'h0};
  int cyc, errs, checks, pulse_cnt;
  bit first_run;
  bit sel_f [64];
  int run_f [64];
  int script [11] = '{3, 1, 0, 0, 0, 0, 0, 0, 0, 3, 2};

  vga_display_pipe #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_ACT(SA), .ADDR_W(AW), .RD_LAT(LAT), .BORDER(BD), .BLINK_FRAMES(BF)
  ) dut (
    .vga_clk(clk), .rst(rst), .warning_signal(warning), .pic_data(pic_data),
    .hor_syn(hor_syn), .ver_syn(ver_syn), .pic_select(pic_select),
    .rgb_red(rgb_red), .rgb_green(rgb_green), .rgb_blue(rgb_blue),
    .pic_addr(pic_addr), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // picture memory with LAT clocks of read latency
  always @(posedge clk) begin
    rd_q[0] <= mem[pic_addr];
    for (int i = 1; i < LAT; i++) rd_q[i] <= rd_q[i-1];
  end
  assign pic_data = rd_q[LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // address = visible pixels seen so far in the frame, minus one
  function automatic int exp_addr(input int p);
    int h = p % HT, v = p / HT;
    int n = v < VA ? v * HA + (h < HA ? h + 1 : HA) : VA * HA;
    return n > 0 ? n - 1 : 0;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_rgb"}, 32'({rgb_red, rgb_green, rgb_blue}), 0);
    check({tag, "_addr"}, 32'(pic_addr), 0);
    check({tag, "_sel"}, 32'(pic_select), 0);
    check({tag, "_hs"}, 32'(hor_syn), 32'(!SA));
    check({tag, "_vs"}, 32'(ver_syn), 32'(!SA));
    check({tag, "_fs"}, 32'(frame_start), 0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) begin
      sel_f[i] = 1'b0;
      run_f[i] = 0;
    end
  endtask

  task automatic check_cycle();
    int q, p, h, v, f;
    logic [15:0] d;
    logic [11:0] rgb_e;
    bit hs_e, vs_e, fs_e, brd;
    check("addr", 32'(pic_addr), 32'(exp_addr(cyc % FT)));
    check("pic_select", 32'(pic_select), 32'(sel_f[cyc / FT]));
    q = cyc - LAT;
    hs_e = 0; vs_e = 0; fs_e = 0; rgb_e = '0;
    if (q >= 0) begin
      p = q % FT; h = p % HT; v = p / HT; f = q / FT;
      hs_e = h >= HA + HFP && h < HA + HFP + HS;
      vs_e = v >= VA + VFP && v < VA + VFP + VS;
      fs_e = p == 0;
      if (h < HA && v < VA) begin
        d = mem[exp_addr(p)];
        brd = h < BD || h >= HA - BD || v < BD || v >= VA - BD;
        rgb_e = brd && sel_f[f] && (run_f[f] / BF) % 2 == 0 ? 12'hF00 : {d[15:12], d[10:7], d[4:1]};
      end
    end
    check("hor_syn", 32'(hor_syn), 32'(hs_e ? SA : !SA));
    check("ver_syn", 32'(ver_syn), 32'(vs_e ? SA : !SA));
    check("frame_start", 32'(frame_start), 32'(fs_e));
    check("rgb", 32'({rgb_red, rgb_green, rgb_blue}), 32'(rgb_e));
  endtask

  // one pixel clock: check, update frame model, drive warning (changes only mid-frame)
  task automatic step();
    int p = cyc % FT, f = cyc / FT, a;
    check_cycle();
    if (p == FT - 1) begin
      sel_f[f+1] = warning;
      run_f[f+1] = warning && sel_f[f] ? run_f[f] + 1 : 0;
    end
    if (pulse_cnt > 0) begin
      pulse_cnt--;
      if (pulse_cnt == 0) warning = ~warning;
    end
    if (p == FT / 2) begin
      a = first_run && f < 11 ? script[f] : int'($urandom_range(0, 3));
      if (a == 1) warning = 1'b1;
      else if (a == 2) warning = 1'b0;
      else if (a == 3) begin
        warning = ~warning;
        pulse_cnt = 10;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    errs = 0; checks = 0; cyc = 0; pulse_cnt = 0; first_run = 1'b1;
    rst = 1'b1; warning = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
    clear_model();
    repeat (5) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    repeat (30 * FT + 3 * HT + 7) step();
    rst = 1'b1;
    #1;
    check_reset("midline");
    repeat (3) @(negedge clk);
    rst = 1'b0; cyc = 0; pulse_cnt = 0; first_run = 1'b0;
    clear_model();
    repeat (6 * FT) step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
